_cmp_pipe_impl: RTL and testbench
=================================

Name: _cmp_pipe_impl

Overview:
- Parametrised, pipelined magnitude comparator for the execute stage.
- Generalises the single-cycle unsigned less-than unit to:
  - configurable width;
  - signed and unsigned compare;
  - less-than and greater-or-equal ops;
  - all-ones mask or 0/1 result format.
- Resolves operands MSB-first, CHUNK bits per pipeline stage, so wide compares meet timing.
- Uses a valid/ready handshake, carries a tag, and supports flush.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per stage; STAGES = WIDTH/CHUNK (default 4).
- TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all in-flight ops.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts an offered op this cycle.
- in_a  in  WIDTH  operand a (rs1).
- in_b  in  WIDTH  operand b (rs2).
- in_op  in  2  cmp_op_t: CMP_LTU=0, CMP_LT=1, CMP_GEU=2, CMP_GE=3.
- in_mask  in  1  1 = result replicated to all WIDTH bits; 0 = result in bit 0, rest zero.
- in_tag  in  TAG_W  opaque tag, returned with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_res  out  WIDTH  formatted compare result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Signed ops (CMP_LT, CMP_GE) invert bit WIDTH-1 of both operands at entry; the unit then performs an unsigned compare.
- Stage k (k = 0..STAGES-1) combinationally compares chunk [WIDTH-1-k*CHUNK -: CHUNK] of a and b.
  - Inputs: lt_in, gt_in.
  - lt_out = lt_in | (~gt_in & chunk_lt); gt_out = gt_in | (~lt_in & chunk_gt).
  - Outputs are registered with valid, op, mask, tag and the remaining operand bits.
  - Stage 0 enters with lt_in = gt_in = 0.
  - lt and gt are never both 1.
- Result bit: lt for LTU/LT, ~lt for GEU/GE.
  - out_res = {WIDTH{bit}} when mask=1; otherwise {WIDTH-1 zeros, bit}.
  - Equal operands give lt = 0, so LT/LTU return 0 and GE/GEU return 1.
- Latency: an op accepted in cycle N presents out_valid in cycle N+STAGES if no stall occurs. Throughput is 1 op/cycle.
- Stall rule:
  - advance = out_ready | ~out_valid; in_ready = advance.
  - When advance=0 all stage registers hold, including bubbles. This is a global stall with no bubble collapsing.
  - An op is accepted iff in_valid & in_ready.
  - A result is consumed iff out_valid & out_ready.
- Result ordering: results leave in acceptance order.
- Output stability: out_res and out_tag are stable while out_valid=1 and out_ready=0.
- Flush:
  - Clears every stage valid on the next edge.
  - An op offered in the same cycle as flush is not accepted; in_ready is forced to 0 while flush=1.
  - out_valid = 0 the cycle after flush.
- Reset, including mid-operation: all stage valids = 0, flags = 0, out_res = 0, out_tag = 0, out_valid = 0. in_ready = 1 in the first cycle after reset deasserts.
- Reset has priority over flush; flush has priority over accept.
- Data registers of invalid stages are don't-care, but outputs must be zero while out_valid=0.

Optional Feature:
- Macro CMP_PIPE_EQ_OUT_EN.
- Defined:
  - Adds output port out_eq (1 bit) = ~lt & ~gt of the final stage, qualified by out_valid, reset 0.
  - Lets the branch unit reuse the pipeline for BEQ/BNE.
- Undefined: the port is absent and no eq logic is synthesised.
- All other behaviour is identical either way.

Decomposition:
- Package cmp_pkg:
  - cmp_op_t (2-bit enum, above);
  - is_signed(op) and is_ge(op) helper functions;
  - default CHUNK constant.
- One sub-module: _cmp_chunk.
  - Purely combinational, parametrised by CHUNK.
  - Inputs: a_chunk, b_chunk, lt_in, gt_in. Outputs: lt_out, gt_out.
  - Instantiated STAGES times in a generate loop.

Test Plan:
- SLTU mask: WIDTH=32, CHUNK=8; a=0x00000001, b=0xFFFFFFFF, op=LTU, mask=1 -> out_res=0xFFFFFFFF, out_valid exactly 4 cycles after accept, tag echoed.
- Signed and unsigned on the same operands: a=0x80000000, b=0x00000001.
  - op=LT, mask=0 -> out_res=0x00000001.
  - op=LTU -> out_res=0x00000000.
  - op=GEU -> out_res=0x00000001.
- Equal and late mismatch:
  - a=b=0x12345678, op=GE -> 1; op=LT -> 0.
  - a=0x12345677, b=0x12345678, op=LTU -> 1, which checks LSB-stage resolution.
- Backpressure: 6 back-to-back ops with tags 1..6, out_ready held low 3 cycles after the first out_valid.
  - in_ready=0 during the stall.
  - No loss or duplication; tags emerge 1..6 in order with correct results.
- Flush: 3 ops accepted, flush asserted 2 cycles later together with in_valid=1.
  - None of the 3 ops, nor the op offered with flush, ever produces out_valid.
  - The next op accepted after flush returns normally.
- Reset mid-op: rst pulsed while 4 ops are in flight.
  - All outputs 0 on the following cycle; no stale result appears.
  - in_ready=1 once rst is low.

Source files
------------

// File: rtl/_cmp_pipe_impl_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types and helpers for the pipelined magnitude comparator.
//   cmp_op_t          : 2-bit compare opcode (LTU, LT, GEU, GE)
//   CMP_CHUNK_DEFAULT : default number of operand bits resolved per stage
//   is_signed(op)     : 1 for the signed opcodes (LT, GE)
//   is_ge(op)         : 1 for the greater-or-equal opcodes (GEU, GE)
// -----------------------------------------------------------------------------
package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_LTU = 2'd0,
      CMP_LT  = 2'd1,
      CMP_GEU = 2'd2,
      CMP_GE  = 2'd3
   } cmp_op_t;

   localparam int CMP_CHUNK_DEFAULT = 8;

   function automatic logic is_signed(input cmp_op_t op);
      return (op == CMP_LT) || (op == CMP_GE);
   endfunction

   function automatic logic is_ge(input cmp_op_t op);
      return (op == CMP_GEU) || (op == CMP_GE);
   endfunction

endpackage

// File: rtl/_cmp_chunk.sv
// -----------------------------------------------------------------------------
// _cmp_chunk
// One combinational slice of the MSB-first magnitude compare. Once a more
// significant slice has decided (lt_in or gt_in set) the decision is carried
// through unchanged; otherwise this slice decides.
// Ports:
//   a_chunk, b_chunk : CHUNK-bit operand slices
//   lt_in, gt_in     : decision from the more significant slices
//   lt_out, gt_out   : decision including this slice (never both 1)
// -----------------------------------------------------------------------------
module _cmp_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_chunk,
   input  logic [CHUNK-1:0] b_chunk,
   input  logic             lt_in,
   input  logic             gt_in,
   output logic             lt_out,
   output logic             gt_out
);

   logic chunk_lt_s;
   logic chunk_gt_s;

   assign chunk_lt_s = (a_chunk < b_chunk);
   assign chunk_gt_s = (a_chunk > b_chunk);

   assign lt_out = lt_in | (~gt_in & chunk_lt_s);
   assign gt_out = gt_in | (~lt_in & chunk_gt_s);

endmodule

// File: rtl/_cmp_pipe_impl.sv
// -----------------------------------------------------------------------------
// _cmp_pipe_impl
// Pipelined signed/unsigned magnitude comparator. Operands are resolved
// MSB-first, CHUNK bits per stage, giving a latency of WIDTH/CHUNK cycles at
// one op per cycle. A single global stall (advance) freezes every stage.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : kill every in-flight op on the next edge
//   in_valid/in_ready   : input handshake (in_ready low while flush=1)
//   in_a, in_b          : operands
//   in_op               : cmp_op_t opcode
//   in_mask             : 1 = result replicated over WIDTH bits, 0 = bit 0
//   in_tag              : opaque tag returned with the result
//   out_valid/out_ready : output handshake
//   out_res, out_tag    : formatted result and its tag (zero when idle)
//   out_eq              : operands equal; present only with
//                         CMP_PIPE_EQ_OUT_EN defined
// -----------------------------------------------------------------------------
module _cmp_pipe_impl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = CMP_CHUNK_DEFAULT,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_mask,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic [TAG_W-1:0] out_tag
`ifdef CMP_PIPE_EQ_OUT_EN
   ,
   output logic             out_eq
`endif
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   logic    advance_s;
   logic    accept_s;
   logic    sign_flip_s;
   logic    last_valid_s;
   logic    res_bit_s;
   cmp_op_t in_op_s;

   assign in_op_s      = cmp_op_t'(in_op);
   assign sign_flip_s  = is_signed(in_op_s);
   assign last_valid_s = g_stage[LAST].valid_q;
   assign advance_s    = out_ready | ~last_valid_s;
   assign in_ready     = advance_s & ~flush;
   assign accept_s     = in_valid & in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still unresolved when they reach this stage.
      localparam int REM_IN = WIDTH - k * CHUNK;

      logic [REM_IN-1:0] a_s;
      logic [REM_IN-1:0] b_s;
      logic              lt_in_s;
      logic              gt_in_s;
      logic              lt_out_s;
      logic              gt_out_s;
      logic              valid_in_s;
      logic              mask_in_s;
      cmp_op_t           op_in_s;
      logic [TAG_W-1:0]  tag_in_s;

      logic              valid_q;
      logic              valid_d;
      logic              lt_q;
      logic              gt_q;
      logic              mask_q;
      cmp_op_t           op_q;
      logic [TAG_W-1:0]  tag_q;

      if (k == 0) begin : g_entry
         // Flipping the sign bits turns a signed compare into an unsigned one.
         assign a_s        = in_a ^ {sign_flip_s, {(WIDTH-1){1'b0}}};
         assign b_s        = in_b ^ {sign_flip_s, {(WIDTH-1){1'b0}}};
         assign lt_in_s    = 1'b0;
         assign gt_in_s    = 1'b0;
         assign valid_in_s = accept_s;
         assign op_in_s    = in_op_s;
         assign mask_in_s  = in_mask;
         assign tag_in_s   = in_tag;
      end else begin : g_link
         assign a_s        = g_stage[k-1].g_rem.a_rem_q;
         assign b_s        = g_stage[k-1].g_rem.b_rem_q;
         assign lt_in_s    = g_stage[k-1].lt_q;
         assign gt_in_s    = g_stage[k-1].gt_q;
         assign valid_in_s = g_stage[k-1].valid_q;
         assign op_in_s    = g_stage[k-1].op_q;
         assign mask_in_s  = g_stage[k-1].mask_q;
         assign tag_in_s   = g_stage[k-1].tag_q;
      end

      _cmp_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a_chunk (a_s[REM_IN-1 -: CHUNK]),
         .b_chunk (b_s[REM_IN-1 -: CHUNK]),
         .lt_in   (lt_in_s),
         .gt_in   (gt_in_s),
         .lt_out  (lt_out_s),
         .gt_out  (gt_out_s)
      );

      // Stage valid: flush kills, stall holds (bubbles included).
      always_comb begin
         valid_d = valid_q;
         if (flush) begin
            valid_d = 1'b0;
         end else if (advance_s) begin
            valid_d = valid_in_s;
         end else begin
            valid_d = valid_q;
         end
      end

      // Stage control/flag registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            mask_q  <= 1'b0;
            op_q    <= CMP_LTU;
            tag_q   <= {TAG_W{1'b0}};
         end else begin
            valid_q <= valid_d;
            if (advance_s) begin
               lt_q   <= lt_out_s;
               gt_q   <= gt_out_s;
               mask_q <= mask_in_s;
               op_q   <= op_in_s;
               tag_q  <= tag_in_s;
            end
         end
      end

      // Only the not-yet-compared low bits travel on; the last stage has none.
      if (k < LAST) begin : g_rem
         logic [REM_IN-CHUNK-1:0] a_rem_q;
         logic [REM_IN-CHUNK-1:0] b_rem_q;

         // Remaining operand bits for the next stage.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_rem_q <= {(REM_IN-CHUNK){1'b0}};
               b_rem_q <= {(REM_IN-CHUNK){1'b0}};
            end else if (advance_s) begin
               a_rem_q <= a_s[REM_IN-CHUNK-1:0];
               b_rem_q <= b_s[REM_IN-CHUNK-1:0];
            end
         end
      end
   end

   assign res_bit_s = is_ge(g_stage[LAST].op_q) ? ~g_stage[LAST].lt_q
                                                :  g_stage[LAST].lt_q;

   // Result formatting; everything is forced to zero while no result is valid.
   always_comb begin
      out_valid = last_valid_s;
      out_res   = {WIDTH{1'b0}};
      out_tag   = {TAG_W{1'b0}};
      if (last_valid_s) begin
         out_tag = g_stage[LAST].tag_q;
         if (g_stage[LAST].mask_q) begin
            out_res = {WIDTH{res_bit_s}};
         end else begin
            out_res = {{(WIDTH-1){1'b0}}, res_bit_s};
         end
      end else begin
         out_tag = {TAG_W{1'b0}};
         out_res = {WIDTH{1'b0}};
      end
   end

`ifdef CMP_PIPE_EQ_OUT_EN
   assign out_eq = last_valid_s & ~g_stage[LAST].lt_q & ~g_stage[LAST].gt_q;
`endif

endmodule

// File: tb/tb__cmp_pipe_impl.sv
// -----------------------------------------------------------------------------
// tb__cmp_pipe_impl
// Self-checking bench for _cmp_pipe_impl (WIDTH=32, CHUNK=8, TAG_W=5).
// A table of directed vectors plus random ops feed a scoreboard; hand-written
// sequences cover backpressure, flush and reset while ops are in flight.
// -----------------------------------------------------------------------------
module tb__cmp_pipe_impl;
   import cmp_pkg::*;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int TAG_W = 5;
   localparam int NV    = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_op;
   logic             in_mask;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic [TAG_W-1:0] out_tag;
`ifdef CMP_PIPE_EQ_OUT_EN
   logic             out_eq;
`endif

   _cmp_pipe_impl #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_mask   (in_mask),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_tag   (out_tag)
`ifdef CMP_PIPE_EQ_OUT_EN
      ,
      .out_eq    (out_eq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       op;
      logic             mask;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] exp;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic [TAG_W-1:0] tag;
      int               acc;
      bit               lat;
      bit               eq;
   } exp_t;

   vec_t             vecs [NV];
   exp_t             sb_q [$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   logic [WIDTH-1:0] drv_exp;
   bit               drv_lat;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Independent reference using the simulator's own signed/unsigned compare.
   function automatic logic [WIDTH-1:0] ref_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] op, input logic m);
      logic r;
      case (op)
         2'd0:    r = (a < b);
         2'd1:    r = ($signed(a) < $signed(b));
         2'd2:    r = !(a < b);
         default: r = !($signed(a) < $signed(b));
      endcase
      return m ? {WIDTH{r}} : {{(WIDTH-1){1'b0}}, r};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: push on accept, pop and compare on consume.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("res", out_res, e.res);
               chk("tag", out_tag, e.tag);
               if (e.lat) chk("latency", cyc - e.acc, 64'd4);
`ifdef CMP_PIPE_EQ_OUT_EN
               chk("eq", out_eq, e.eq);
`endif
            end
         end
         if (flush) begin
            sb_q.delete();
         end else if (in_valid && in_ready) begin
            e.res = drv_exp;
            e.tag = in_tag;
            e.acc = cyc;
            e.lat = drv_lat;
            e.eq  = (in_a == in_b);
            sb_q.push_back(e);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op,
                       input logic m, input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp,
                       input bit lat);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_mask  = m;
      in_tag   = tag;
      drv_exp  = exp;
      drv_lat  = lat;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && sb_q.size() != 0; t++) @(negedge clk);
      chk("drain_empty", sb_q.size(), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic count_outs(input string nm);
      int cnt = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk(nm, cnt, 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [1:0]       rop;
      logic             rm;

      vecs[0]  = '{32'h0000_0001, 32'hFFFF_FFFF, 2'd0, 1'b1, 5'd7,  32'hFFFF_FFFF};
      vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 2'd1, 1'b0, 5'd8,  32'h0000_0001};
      vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 2'd0, 1'b0, 5'd9,  32'h0000_0000};
      vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 2'd2, 1'b0, 5'd10, 32'h0000_0001};
      vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 2'd3, 1'b0, 5'd11, 32'h0000_0001};
      vecs[5]  = '{32'h1234_5678, 32'h1234_5678, 2'd1, 1'b0, 5'd12, 32'h0000_0000};
      vecs[6]  = '{32'h1234_5677, 32'h1234_5678, 2'd0, 1'b0, 5'd13, 32'h0000_0001};
      vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 1'b1, 5'd14, 32'hFFFF_FFFF};
      vecs[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 2'd3, 1'b1, 5'd15, 32'hFFFF_FFFF};
      vecs[9]  = '{32'h0001_0000, 32'h0000_FFFF, 2'd2, 1'b1, 5'd16, 32'hFFFF_FFFF};
      vecs[10] = '{32'h0000_FFFF, 32'h0001_0000, 2'd2, 1'b0, 5'd17, 32'h0000_0000};
      vecs[11] = '{32'h1234_5678, 32'h1234_5678, 2'd2, 1'b1, 5'd18, 32'hFFFF_FFFF};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_op = 2'd0; in_mask = 1'b0; in_tag = '0; out_ready = 1'b1;
      drv_exp = '0; drv_lat = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 64'd0);
      chk("rst_out_res", out_res, 64'd0);
      chk("rst_out_tag", out_tag, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 64'd1);
      @(posedge clk);
      #1;

      // Directed table, back-to-back, fixed 4-cycle latency.
      for (int i = 0; i < NV; i++)
         send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].mask, vecs[i].tag, vecs[i].exp, 1'b1);
      drain();

      // Random ops, half of them differing in a single bit to reach late stages.
      for (int i = 0; i < 16; i++) begin
         ra  = $urandom;
         rb  = (i % 4 == 3) ? ra : ((i % 2 == 1) ? $urandom : (ra ^ (32'h1 << $urandom_range(31, 0))));
         rop = 2'($urandom_range(3, 0));
         rm  = 1'($urandom_range(1, 0));
         send(ra, rb, rop, rm, 5'(i), ref_res(ra, rb, rop, rm), 1'b1);
      end
      drain();

      // Backpressure: 6 ops, out_ready low for 3 cycles after first result.
      fork
         begin : bp_send
            for (int i = 1; i <= 6; i++) begin
               ra = 32'h1000_0000 * i;
               rb = 32'h3000_0000;
               send(ra, rb, 2'(i % 4), 1'(i % 2), 5'(i), ref_res(ra, rb, 2'(i % 4), 1'(i % 2)), 1'b0);
            end
         end
         begin : bp_stall
            bit seen = 1'b0;
            for (int t = 0; t < 40 && !seen; t++) begin
               @(negedge clk);
               seen = out_valid;
            end
            chk("bp_first_out", seen, 64'd1);
            @(posedge clk);
            #1 out_ready = 1'b0;
            for (int t = 0; t < 3; t++) begin
               @(negedge clk);
               chk("bp_in_ready_low", in_ready, 64'd0);
               chk("bp_out_valid_held", out_valid, 64'd1);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush: 3 ops in flight plus one offered together with flush.
      for (int i = 0; i < 3; i++)
         send(32'h0000_0005, 32'h0000_0009, 2'd0, 1'b0, 5'(24 + i), 32'h0000_0001, 1'b1);
      in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2; in_op = 2'd0; in_mask = 1'b1;
      in_tag = 5'd27; drv_exp = 32'hFFFF_FFFF; flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 64'd0);
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      count_outs("flush_no_out");
      send(32'hFFFF_FFFE, 32'h0000_0003, 2'd3, 1'b1, 5'd28, 32'h0000_0000, 1'b1);
      drain();

      // Reset while 4 ops are in flight.
      for (int i = 0; i < 4; i++)
         send(32'h0000_0001, 32'h0000_0002, 2'd0, 1'b1, 5'(20 + i), 32'hFFFF_FFFF, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 64'd0);
      chk("midrst_out_res", out_res, 64'd0);
      chk("midrst_out_tag", out_tag, 64'd0);
      chk("midrst_in_ready", in_ready, 64'd1);
      @(posedge clk);
      #1;
      count_outs("midrst_no_stale");
      send(32'h8000_0000, 32'h7FFF_FFFF, 2'd1, 1'b0, 5'd30, 32'h0000_0001, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
